// File: rtl/cpu7_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : cpu7_ifu_ibuf
// Description : In-order instruction buffer between fetch and decode, with
//               branch-cancel flush and exception-triggered enqueue hold.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu7_ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fdp_ibuf_valid,
    input  logic [31:0]      fdp_ibuf_pc,
    input  logic [31:0]      fdp_ibuf_inst,
    input  logic             fdp_ibuf_ex,
    input  logic [5:0]       fdp_ibuf_exccode,
    output logic             ibuf_fdp_ready,
    input  logic             br_cancel,
    output logic             ibuf_dec_valid,
    output logic [31:0]      ibuf_dec_pc,
    output logic [31:0]      ibuf_dec_inst,
    output logic             ibuf_dec_ex,
    output logic [5:0]       ibuf_dec_exccode,
    input  logic             dec_ibuf_ready,
    output logic [PTR_W:0]   ibuf_count
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] c_one   = (PTR_W+1)'(1);

    // Entry layout: {pc[70:39], inst[38:7], ex[6], exccode[5:0]}
    logic [70:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ex_hold;

    logic             w_push;
    logic             w_pop;
    logic [70:0]      w_head;

    always_comb begin
        ibuf_fdp_ready = (r_count != c_depth) & ~r_ex_hold;
        ibuf_dec_valid = (r_count != '0);
        w_push         = fdp_ibuf_valid & ibuf_fdp_ready & ~br_cancel;
        w_pop          = ibuf_dec_valid & dec_ibuf_ready & ~br_cancel;
        w_head         = r_mem[r_rd_ptr];
    end

    assign ibuf_dec_pc      = w_head[70:39];
    assign ibuf_dec_inst    = w_head[38:7];
    assign ibuf_dec_ex      = w_head[6];
    assign ibuf_dec_exccode = w_head[5:0];
    assign ibuf_count       = r_count;

    // Storage carries no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {fdp_ibuf_pc, fdp_ibuf_inst, fdp_ibuf_ex, fdp_ibuf_exccode};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ex_hold <= 1'b0;
        end else if (br_cancel) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ex_hold <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (fdp_ibuf_ex) begin
                    r_ex_hold <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu7_ifu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu7_ifu_ibuf
// Description : Vector-table bench for cpu7_ifu_ibuf with a queue scoreboard
//               checking every entry consumed by decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu7_ifu_ibuf;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic        rstn;
        logic        valid;
        logic [31:0] pc;
        logic        ex;
        logic [5:0]  exccode;
        logic        cancel;
        logic        dready;
        int          exp_count;
        logic        exp_ready;
        logic        exp_dvalid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [5:0]  exccode;
    } ent_t;

    logic             clock;
    logic             reset;
    logic             fdp_ibuf_valid;
    logic [31:0]      fdp_ibuf_pc;
    logic [31:0]      fdp_ibuf_inst;
    logic             fdp_ibuf_ex;
    logic [5:0]       fdp_ibuf_exccode;
    logic             ibuf_fdp_ready;
    logic             br_cancel;
    logic             ibuf_dec_valid;
    logic [31:0]      ibuf_dec_pc;
    logic [31:0]      ibuf_dec_inst;
    logic             ibuf_dec_ex;
    logic [5:0]       ibuf_dec_exccode;
    logic             dec_ibuf_ready;
    logic [PTR_W:0]   ibuf_count;

    vec_t r_vecs[$];
    ent_t r_sb[$];
    logic r_m_hold;
    int   r_n_vec;
    int   r_n_chk;
    int   r_n_fail;

    cpu7_ifu_ibuf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .fdp_ibuf_valid   (fdp_ibuf_valid),
        .fdp_ibuf_pc      (fdp_ibuf_pc),
        .fdp_ibuf_inst    (fdp_ibuf_inst),
        .fdp_ibuf_ex      (fdp_ibuf_ex),
        .fdp_ibuf_exccode (fdp_ibuf_exccode),
        .ibuf_fdp_ready   (ibuf_fdp_ready),
        .br_cancel        (br_cancel),
        .ibuf_dec_valid   (ibuf_dec_valid),
        .ibuf_dec_pc      (ibuf_dec_pc),
        .ibuf_dec_inst    (ibuf_dec_inst),
        .ibuf_dec_ex      (ibuf_dec_ex),
        .ibuf_dec_exccode (ibuf_dec_exccode),
        .dec_ibuf_ready   (dec_ibuf_ready),
        .ibuf_count       (ibuf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F00;
    endfunction

    function automatic vec_t mk(input logic rstn, input logic valid, input logic [31:0] pc,
                                input logic ex, input logic [5:0] exc, input logic cancel,
                                input logic dready, input int cnt, input logic rdy,
                                input logic dv);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.pc = pc; v.ex = ex; v.exccode = exc;
        v.cancel = cancel; v.dready = dready;
        v.exp_count = cnt; v.exp_ready = rdy; v.exp_dvalid = dv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        r_n_chk++;
        if (act !== exp) begin
            r_n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (vector %0d)", name, act, exp, r_n_vec);
        end
    endtask

    // Called just after a falling edge: drive, score the pop, clock, then compare.
    task automatic apply(input vec_t v);
        ent_t e;
        logic m_ready;
        r_n_vec++;
        reset            = v.rstn;
        fdp_ibuf_valid   = v.valid;
        fdp_ibuf_pc      = v.pc;
        fdp_ibuf_inst    = inst_of(v.pc);
        fdp_ibuf_ex      = v.ex;
        fdp_ibuf_exccode = v.exccode;
        br_cancel        = v.cancel;
        dec_ibuf_ready   = v.dready;
        m_ready = (r_sb.size() != DEPTH) && !r_m_hold;
        if (!v.rstn || v.cancel) begin
            r_sb.delete();
            r_m_hold = 1'b0;
        end else begin
            if (v.dready && r_sb.size() != 0) begin
                e = r_sb.pop_front();
                check("head_valid", {31'd0, ibuf_dec_valid}, 32'd1);
                check("head_pc", ibuf_dec_pc, e.pc);
                check("head_inst", ibuf_dec_inst, e.inst);
                check("head_ex_code", {25'd0, ibuf_dec_ex, ibuf_dec_exccode}, {25'd0, e.ex, e.exccode});
            end
            if (v.valid && m_ready) begin
                e.pc = v.pc; e.inst = inst_of(v.pc); e.ex = v.ex; e.exccode = v.exccode;
                r_sb.push_back(e);
                if (v.ex) r_m_hold = 1'b1;
            end
        end
        @(posedge clock);
        @(negedge clock);
        check("count", {29'd0, ibuf_count}, v.exp_count);
        check("fdp_ready", {31'd0, ibuf_fdp_ready}, {31'd0, v.exp_ready});
        check("dec_valid", {31'd0, ibuf_dec_valid}, {31'd0, v.exp_dvalid});
    endtask

    initial begin
        vec_t v;
        int   waited;
        r_n_vec = 0; r_n_chk = 0; r_n_fail = 0; r_m_hold = 1'b0;
        reset = 1'b0; fdp_ibuf_valid = 1'b0; fdp_ibuf_pc = '0; fdp_ibuf_inst = '0;
        fdp_ibuf_ex = 1'b0; fdp_ibuf_exccode = '0; br_cancel = 1'b0; dec_ibuf_ready = 1'b0;

        // Reset, then fill to full with one dropped push, then drain.
        r_vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        r_vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            r_vecs.push_back(mk(1, 1, 32'h1c00_0000 + 32'(4*i), 0, 0, 0, 0, i+1, i < 3, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0010, 0, 0, 0, 0, 4, 0, 1));
        for (int i = 0; i < 4; i++)
            r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3-i, 1, i < 3));
        // Streaming across pointer wrap.
        for (int i = 0; i < 12; i++)
            r_vecs.push_back(mk(1, 1, 32'h1c00_0040 + 32'(4*i), 0, 0, 0, 1, 1, 1, 1));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // Flush mid-stream discards the presented instruction.
        for (int i = 0; i < 3; i++)
            r_vecs.push_back(mk(1, 1, 32'h1c00_0080 + 32'(4*i), 0, 0, 0, 0, i+1, 1, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0100, 0, 0, 1, 1, 0, 1, 0));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0200, 0, 0, 0, 0, 1, 1, 1));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // Exception hold persists past the pop until a cancel.
        r_vecs.push_back(mk(1, 1, 32'h1c00_0020, 1, 6'h08, 0, 0, 1, 0, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0024, 0, 0, 0, 0, 1, 0, 1));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0028, 0, 0, 0, 1, 0, 0, 0));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        // Simultaneous push and pop at count 2.
        r_vecs.push_back(mk(1, 1, 32'h1c00_0300, 0, 0, 0, 0, 1, 1, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0304, 0, 0, 0, 0, 2, 1, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0308, 0, 0, 0, 1, 2, 1, 1));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // Reset mid-operation clears entries and the exception hold.
        r_vecs.push_back(mk(1, 1, 32'h1c00_0400, 0, 0, 0, 0, 1, 1, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0404, 0, 0, 0, 0, 2, 1, 1));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0408, 1, 6'h03, 0, 0, 3, 0, 1));
        r_vecs.push_back(mk(0, 1, 32'h1c00_040c, 0, 0, 0, 1, 0, 1, 0));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        r_vecs.push_back(mk(1, 1, 32'h1c00_0500, 0, 0, 0, 0, 1, 1, 1));
        r_vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));

        foreach (r_vecs[i]) apply(r_vecs[i]);

        // Hand sequence: pop at full while fetch keeps offering (no pass-through).
        for (int i = 0; i < 4; i++)
            apply(mk(1, 1, 32'h1c00_0600 + 32'(4*i), 0, 0, 0, 0, i+1, i < 3, 1));
        apply(mk(1, 1, 32'h1c00_0610, 0, 0, 0, 1, 3, 1, 1));
        apply(mk(1, 1, 32'h1c00_0614, 0, 0, 0, 1, 3, 1, 1));
        apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));

        // Hand sequence: bounded wait for a pushed entry to surface at decode.
        apply(mk(1, 1, 32'h1c00_0700, 0, 6'h11, 0, 0, 1, 1, 1));
        fdp_ibuf_valid = 1'b0;
        waited = 0;
        while (!ibuf_dec_valid && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        check("surface_wait", waited, 0);
        apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        check("sb_empty", r_sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", r_n_vec, r_n_fail);
        $finish;
    end

endmodule
`default_nettype wire
